// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM states and default width.
// SIGNED_MULT_EN adds the SIGN state used for two's-complement results.
package mult_pkg;

  localparam int unsigned MULT_WIDTH_DEF = 4;

`ifdef SIGNED_MULT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    SIGN = 2'd3
  } mult_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;
`endif

endpackage

// File: rtl/ripple_add_n.sv
// N-bit ripple-carry adder with carry-out, used for the partial-product add.
module ripple_add_n
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_WIDTH_DEF
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with valid/ready handshakes on both sides.
// Define SIGNED_MULT_EN for two's-complement operands (adds one SIGN cycle).
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  mult_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [ACC_W-1:0]  acc_q;
  logic              in_ready_q;
  logic              out_valid_q;
`ifdef SIGNED_MULT_EN
  logic              neg_q;
`endif

  logic [WIDTH-1:0]  addend_c;
  logic [WIDTH-1:0]  sum_c;
  logic              carry_c;

  // Partial product: multiplicand gated by the current multiplier LSB, added to the upper half.
  assign addend_c = mcand_q & {WIDTH{mplier_q[0]}};

  ripple_add_n #(
    .N (WIDTH)
  ) u_add (
    .x    (acc_q[ACC_W-1:WIDTH]),
    .y    (addend_c),
    .sum  (sum_c),
    .cout (carry_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SIGNED_MULT_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
`ifdef SIGNED_MULT_EN
            // Magnitudes fit WIDTH bits unsigned, including the most-negative value.
            mcand_q  <= a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
            mplier_q <= b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
`else
            mcand_q  <= a;
            mplier_q <= b;
`endif
            cnt_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= {carry_c, sum_c, acc_q[WIDTH-1:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_MULT_EN
            state_q     <= SIGN;
`else
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`endif
          end
        end
`ifdef SIGNED_MULT_EN
        SIGN: begin
          if (neg_q) begin
            acc_q <= ~acc_q + ACC_W'(1);
          end
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized self-checking bench for shift_add_mult against an arithmetic reference model.
module tb_shift_add_mult;

  localparam int W  = 4;
  localparam int PW = 2 * W;
`ifdef SIGNED_MULT_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;

  int n_checks = 0;
  int n_errors = 0;

  time last_acc;
  bit  last_acc_ok   = 1'b0;
  int  last_hold     = 1;

  shift_add_mult #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product straight from integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SIGNED_MULT_EN
    if (x[W-1]) sx = sx - (longint'(1) << W);
    if (y[W-1]) sy = sy - (longint'(1) << W);
`endif
    return PW'(sx * sy);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input int hold, input bit inject);
    logic [PW-1:0] exp_p;
    int            lat;
    time           t_acc;
    exp_p = model(op_a, op_b);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    @(posedge clk);
    t_acc = $time;
    if (last_acc_ok && last_hold == 0)
      check("throughput", (t_acc - last_acc) / 10, LAT + 2);
    last_acc    = t_acc;
    last_acc_ok = 1'b1;
    last_hold   = hold;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      in_valid = inject && (lat == 0);
      if (inject) begin
        a = 3;
        b = 3;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, LAT);
    check("product", p, exp_p);
    check("busy_not_ready", in_ready, 0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_p", p, exp_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
  endtask

  // Abort a multiplication with a one-cycle reset and make sure nothing stale emerges.
  task automatic reset_mid_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    bit stale;
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_p", p, 0);
    stale = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("abort_stale", stale, 0);
    check("abort_p_idle", p, 0);
    last_acc_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 4'hF;
    b         = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_p", p, 0);
    resetn    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    run_op(4'd15, 4'd15, 0, 1'b0);
    run_op(4'd0,  4'd9,  0, 1'b0);
    run_op(4'd6,  4'd7,  5, 1'b0);
    run_op(4'd5,  4'd5,  0, 1'b1);
    run_op(4'd8,  4'd7,  0, 1'b0);
    run_op(4'd8,  4'd8,  1, 1'b0);
    reset_mid_op(4'd13, 4'd11);
    run_op(4'd0,  4'd0,  0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
